apb_regfile_slave: RTL and testbench

- APB slave that sits directly downstream of the APB master and terminates its transfers.
- Decodes an address window, stores 32-bit words in a small register array, and inserts programmable wait states via pready_o.
- Flags errors with pslverr_o.
- Word 0 is a read-only ID register. The default window covers 32'hDEAD_CAFE, so the existing master's read-then-write-back ping-pong traffic lands on word 15.

---
 rtl/apb_regfile_slave.sv | 134 +++++++++++++
 tb/tb_apb_regfile_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB slave terminating the master's transfers.
// It decodes a DEPTH-word address window, stores 32-bit words, and
// exposes word 0 as a read-only ID register. Every transfer gets a
// fixed number of wait states, and errors are flagged on pslverr_o.
// Optional build macro APB_SLV_RAND_WAIT_EN: a free-running 4-bit LFSR
// sets the per-transfer wait states instead of WAIT_CYCLES.
module apb_regfile_slave #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAC0,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [3:0]      wait_load;
    logic [31:0]     mem [DEPTH];
    logic            hit;
    logic [AW-1:0]   idx;
    logic            is_id;
    logic            err;
    logic            commit;

    // Byte-lane bits are deliberately ignored: there is no alignment error.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^paddr_i[1:0];

`ifdef APB_SLV_RAND_WAIT_EN
    logic [3:0] lfsr;

    // Free-running LFSR. It is seeded non-zero and can never reach 0,
    // so every transfer gets at least one wait state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 4'hE;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[1] ^ lfsr[3]};
        end
    end

    assign wait_load = lfsr;
`else
    assign wait_load = 4'(WAIT_CYCLES);
`endif

    // Address decode and completion/error qualification.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first
        // so that no path leaves it unassigned and infers a latch.
        hit       = (paddr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
        idx       = paddr_i[AW+1:2];
        is_id     = (idx == '0);
        err       = ~hit | (pwrite_i & is_id);
        pready_o  = (state == ST_ACCESS) & psel_i & penable_i & (wait_cnt == 4'd0);
        pslverr_o = pready_o & err;
        commit    = pready_o & pwrite_i & ~err;
        prdata_o  = '0;
        if (pready_o && !pwrite_i && !err) begin
            prdata_o = is_id ? ID_VALUE : mem[idx];
        end
    end

    // Bus-tracking FSM and wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together at the clock edge, whatever the statement order.
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A psel_i & penable_i pair seen here is a protocol
                    // violation. It is ignored and the FSM stays idle.
                    if (psel_i && !penable_i) begin
                        state    <= ST_SETUP;
                        wait_cnt <= wait_load;
                    end
                end
                ST_SETUP: begin
                    if (!psel_i) begin
                        state <= ST_IDLE;
                    end else if (penable_i) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!psel_i || pready_o) begin
                        // This covers both completion and abort by the master.
                        state <= ST_IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register array: a write commits only on an error-free completion.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the array is in the reset domain because it must read as zero
        // after reset. That also rules out mapping it onto reset-less RAM macros.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx] <= pwdata_i;
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed bench for apb_regfile_slave.
// u_slv uses the default parameters (WAIT_CYCLES=2).
// u_slv_z uses WAIT_CYCLES=0 for the zero-wait back-to-back case.
// One shared bus drives both; sel_z picks which instance gets psel.
module tb_apb_regfile_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        sel_z;

    logic        pready_w, pslverr_w, pready_z, pslverr_z;
    logic [31:0] prdata_w, prdata_z;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;
    localparam logic [31:0] A_ID     = 32'hDEAD_CAC0;
    localparam logic [31:0] A_W3     = 32'hDEAD_CACC;
    localparam logic [31:0] A_W5     = 32'hDEAD_CAD4;
    localparam logic [31:0] A_W6     = 32'hDEAD_CAD8;
    localparam logic [31:0] A_W15    = 32'hDEAD_CAFE;
    localparam logic [31:0] A_OUT    = 32'h0000_103C;

    always #5 clk = ~clk;

    apb_regfile_slave u_slv (
        .clk       (clk),
        .reset     (reset),
        .psel_i    (psel & ~sel_z),
        .penable_i (penable),
        .paddr_i   (paddr),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pready_o  (pready_w),
        .prdata_o  (prdata_w),
        .pslverr_o (pslverr_w)
    );

    apb_regfile_slave #(.WAIT_CYCLES(0)) u_slv_z (
        .clk       (clk),
        .reset     (reset),
        .psel_i    (psel & sel_z),
        .penable_i (penable),
        .paddr_i   (paddr),
        .pwrite_i  (pwrite),
        .pwdata_i  (pwdata),
        .pready_o  (pready_z),
        .prdata_o  (prdata_z),
        .pslverr_o (pslverr_z)
    );

    assign pready  = sel_z ? pready_z  : pready_w;
    assign prdata  = sel_z ? prdata_z  : prdata_w;
    assign pslverr = sel_z ? pslverr_z : pslverr_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // One APB transfer. It returns the read data, the error flag and the
    // number of access cycles up to and including the one with pready.
    // The task ends on the negedge of the completion cycle, so a following
    // call starts its setup phase directly after it (back-to-back).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int acc);
        logic done;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        penable = 1'b1;
        acc  = 0;
        done = 1'b0;
        rd   = '0;
        err  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            acc++;
            if (pready) begin
                rd   = prdata;
                err  = pslverr;
                done = 1'b1;
            end
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd, exp_w15;
    logic        err;
    int          acc;

    initial begin
        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel_z = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pready",  {31'd0, pready_w},  32'd0);
        check("rst_prdata",  prdata_w,           32'd0);
        check("rst_pslverr", {31'd0, pslverr_w}, 32'd0);
        check("rst_state",   32'(u_slv.state),   32'd0);
        reset = 1'b1;

        // First read of word 15: no error, zero data, ready on access cycle 3.
        xfer(1'b0, A_W15, 32'd0, rd, err, acc);
        check("rd15_acc",  acc, 32'd3);
        check("rd15_data", rd,  32'd0);
        check("rd15_err",  {31'd0, err}, 32'd0);

        xfer(1'b1, A_W15, 32'h0000_0001, rd, err, acc);
        check("wr15_acc", acc, 32'd3);
        check("wr15_err", {31'd0, err}, 32'd0);
        xfer(1'b0, A_W15, 32'd0, rd, err, acc);
        check("rd15_after_wr", rd, 32'h0000_0001);

        // Ping-pong: each round reads the word and writes it back plus one.
        exp_w15 = 32'h0000_0001;
        for (int r = 0; r < 3; r++) begin
            xfer(1'b0, A_W15, 32'd0, rd, err, acc);
            check("pp_rd", rd, exp_w15);
            xfer(1'b1, A_W15, rd + 32'd1, rd, err, acc);
            exp_w15 = exp_w15 + 32'd1;
        end
        xfer(1'b0, A_W15, 32'd0, rd, err, acc);
        check("pp_final", rd, 32'h0000_0004);

        // ID register: reads return ID_VALUE, writes are rejected.
        xfer(1'b0, A_ID, 32'd0, rd, err, acc);
        check("id_rd", rd, ID_VALUE);
        check("id_rd_err", {31'd0, err}, 32'd0);
        xfer(1'b1, A_ID, 32'h1234_5678, rd, err, acc);
        check("id_wr_err", {31'd0, err}, 32'd1);
        xfer(1'b0, A_ID, 32'd0, rd, err, acc);
        check("id_rd_again", rd, ID_VALUE);

        // Out of window. The index bits alias word 15, which must not change.
        xfer(1'b0, A_OUT, 32'd0, rd, err, acc);
        check("out_rd_err",  {31'd0, err}, 32'd1);
        check("out_rd_data", rd, 32'd0);
        xfer(1'b1, A_OUT, 32'h5555_AAAA, rd, err, acc);
        check("out_wr_err", {31'd0, err}, 32'd1);
        xfer(1'b0, A_W15, 32'd0, rd, err, acc);
        check("out_no_change", rd, 32'h0000_0004);

        // Protocol violation: psel & penable while idle is ignored.
        bus_idle();
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; paddr = A_W15; pwrite = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("viol_pready", {31'd0, pready_w}, 32'd0);
        end
        check("viol_state", 32'(u_slv.state), 32'd0);
        bus_idle();

        // Abort: psel drops during the access phase, so the write is lost.
        xfer(1'b1, A_W5, 32'h0000_00A5, rd, err, acc);
        bus_idle();
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_W5; pwdata = 32'hBAD0_BAD0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("abort_pready", {31'd0, pready_w}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(u_slv.state), 32'd0);
        xfer(1'b0, A_W5, 32'd0, rd, err, acc);
        check("abort_no_write", rd, 32'h0000_00A5);

        // Reset in the middle of an access clears the array and the FSM.
        xfer(1'b1, A_W6, 32'h0000_0066, rd, err, acc);
        bus_idle();
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_W6; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstmid_state",  32'(u_slv.state), 32'd0);
        check("rstmid_pready", {31'd0, pready_w}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        xfer(1'b0, A_W6, 32'd0, rd, err, acc);
        check("rstmid_w6", rd, 32'd0);
        xfer(1'b0, A_W15, 32'd0, rd, err, acc);
        check("rstmid_w15", rd, 32'd0);
        bus_idle();

        // Zero-wait instance: back-to-back write then read on word 3.
        sel_z = 1'b1;
        xfer(1'b1, A_W3, 32'hCAFE_F00D, rd, err, acc);
        check("z_wr_acc", acc, 32'd1);
        check("z_wr_err", {31'd0, err}, 32'd0);
        xfer(1'b0, A_W3, 32'd0, rd, err, acc);
        check("z_rd_acc",  acc, 32'd1);
        check("z_rd_data", rd,  32'hCAFE_F00D);
        bus_idle();
        sel_z = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
